// File: rtl/temporal_mac_ctrl_if.sv
// Bundle of job, ifm handshake and PE-row strobe signals for temporal_mac_ctrl.
// master = job/ifm source, slave = the controller.
interface temporal_mac_ctrl_if #(
    parameter int CWIDTH = 16
);
    // Job request: start is sampled only while the controller is idle.
    logic              start;
    logic [CWIDTH-1:0] num_ifm;

    // ifm handshake: a vector transfers in a cycle where ifm_valid && ifm_ready;
    // ifm_valid may be raised at any time, ifm_ready is asserted only while the
    // controller waits for the next vector and never depends on anything but
    // ifm_valid and controller state.
    logic              ifm_valid;
    logic              ifm_ready;

    // Job status.
    logic              busy;
    logic              done;
    logic [CWIDTH-1:0] ifm_left;

    // PE-row control strobes.
    logic              en_i;
    logic              clr_i;
    logic              en_w;
    logic              clr_w;
    logic              en_o;
    logic              clr_o;
    logic              mac_done;

    modport master (
        output start, num_ifm, ifm_valid,
        input  ifm_ready, busy, done, ifm_left,
        input  en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done
    );

    modport slave (
        input  start, num_ifm, ifm_valid,
        output ifm_ready, busy, done, ifm_left,
        output en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done
    );
endinterface

// File: rtl/temporal_mac_ctrl.sv
// Sequencer for a temporal (unary) MAC PE row: loads weights once per job, then
// streams num_ifm ifm vectors, each held for a RUN_LEN-cycle accumulation window.
module temporal_mac_ctrl #(
    parameter int IWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    temporal_mac_ctrl_if.slave  bus,
    output logic [2:0]          dbg_state
);

    localparam int               RUN_LEN  = 1 << (IWIDTH - 1);
    localparam logic [IWIDTH-1:0] RUN_LAST = IWIDTH'(RUN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOADW  = 3'd2,
        WAIT_I = 3'd3,
        RUN    = 3'd4,
        CLRO   = 3'd5,
        FIN    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IWIDTH-1:0] cnt;
    logic [CWIDTH-1:0] ifm_left;
    logic              run_last;

    logic              busy;
    logic              done;
    logic              ifm_ready;
    logic              en_i;
    logic              clr_i;
    logic              en_w;
    logic              clr_w;
    logic              en_o;
    logic              clr_o;
    logic              mac_done;

    assign run_last = (cnt == RUN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycle counter restarts on every ifm accept so each window is exactly RUN_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == WAIT_I && bus.ifm_valid) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + IWIDTH'(1);
        end
    end

    // num_ifm is captured only at job acceptance; later changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_left <= '0;
        end else if (state == IDLE && bus.start) begin
            ifm_left <= bus.num_ifm;
        end else if (state == RUN && run_last && ifm_left != '0) begin
            ifm_left <= ifm_left - CWIDTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        ifm_ready = 1'b0;
        en_i      = 1'b0;
        clr_i     = 1'b0;
        en_w      = 1'b0;
        clr_w     = 1'b0;
        en_o      = 1'b0;
        clr_o     = 1'b0;
        mac_done  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.num_ifm != '0) ? CLR : FIN;
                end
            end
            CLR: begin
                clr_i     = 1'b1;
                clr_w     = 1'b1;
                clr_o     = 1'b1;
                state_nxt = LOADW;
            end
            LOADW: begin
                en_w      = 1'b1;
                state_nxt = WAIT_I;
            end
            WAIT_I: begin
                en_i      = bus.ifm_valid;
                ifm_ready = bus.ifm_valid;
                if (bus.ifm_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                en_o = 1'b1;
                if (run_last) begin
                    mac_done  = 1'b1;
                    state_nxt = CLRO;
                end
            end
            CLRO: begin
                // ifm_left was already decremented on the RUN exit edge.
                clr_i     = 1'b1;
                clr_o     = 1'b1;
                state_nxt = (ifm_left != '0) ? WAIT_I : FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.ifm_ready = ifm_ready;
    assign bus.ifm_left  = ifm_left;
    assign bus.en_i      = en_i;
    assign bus.clr_i     = clr_i;
    assign bus.en_w      = en_w;
    assign bus.clr_w     = clr_w;
    assign bus.en_o      = en_o;
    assign bus.clr_o     = clr_o;
    assign bus.mac_done  = mac_done;
    assign dbg_state     = state;

    a_mac_done_in_run: assert property (@(posedge clk) disable iff (!rst_n)
        mac_done |-> en_o);
    a_ready_only_waiting: assert property (@(posedge clk) disable iff (!rst_n)
        ifm_ready |-> (state == WAIT_I));
    a_run_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN && !run_last) |=> (state == RUN));

endmodule
